// File: rtl/exponencial_pkg.sv
// Shared types and sizing helpers for the sequential power unit.
package exponencial_pkg;

  // Controller states: wait for start, iterate over exponent bits, present result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } exp_state_t;

  // Reference operand width and its bit-counter width.
  localparam int M_DEF = 4;
  localparam int CW    = $clog2(M_DEF);

  // Bit-index counter width for an M-bit exponent. The result is never below 1,
  // so a counter register always exists even when M is small.
  function automatic int cnt_width(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/exponencial_secuencial_multiplicador.sv
// Unsigned M x M multiplier. It returns the low half of the 2M-bit product
// together with a flag that reports whether the high half is nonzero.
module multiplicador_mxm #(
  parameter int M = 4
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] p_lo,
  output logic         hi_nz
);

  logic [2*M-1:0] p;

  // Full-width product, then split into the kept low half and the overflow indicator.
  always_comb begin
    p     = {{M{1'b0}}, a} * {{M{1'b0}}, b};
    p_lo  = p[M-1:0];
    hi_nz = |p[2*M-1:M];
  end

endmodule

// File: rtl/exponencial_secuencial.sv
// Multi-cycle base**exponente unit using MSB-first square-and-multiply,
// one exponent bit per clock, with exact overflow detection and optional saturation.
module exponencial_secuencial
  import exponencial_pkg::*;
#(
  parameter int M        = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] base,
  input  logic [M-1:0] exponente,
  output logic [M-1:0] resultado,
  output logic         overflow,
  output logic         busy,
  output logic         done
);

  localparam int CNT_W = cnt_width(M);

  exp_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [M-1:0]     acc_q, acc_d;
  logic             ovf_s_q, ovf_s_d;
  logic [M-1:0]     base_q, base_d;
  logic [M-1:0]     exp_q, exp_d;
  logic [M-1:0]     resultado_q, resultado_d;
  logic             overflow_q, overflow_d;

  // Datapath for one iteration: square the accumulator, then optionally multiply by base.
  logic [M-1:0] sq_lo;
  logic         sq_hi_nz;
  logic [M-1:0] mul_lo;
  logic         mul_hi_nz;
  logic         bit_e;
  logic [M-1:0] step_acc;
  logic         step_ovf;

  multiplicador_mxm #(.M(M)) u_square (
    .a     (acc_q),
    .b     (acc_q),
    .p_lo  (sq_lo),
    .hi_nz (sq_hi_nz)
  );

  multiplicador_mxm #(.M(M)) u_mul_base (
    .a     (sq_lo),
    .b     (base_q),
    .p_lo  (mul_lo),
    .hi_nz (mul_hi_nz)
  );

  // One square-and-multiply step on the current exponent bit. Every intermediate
  // value is a prefix power of the final result, so the sticky flag is exact.
  always_comb begin
    bit_e    = exp_q[cnt_q];
    step_acc = bit_e ? mul_lo : sq_lo;
    step_ovf = ovf_s_q | sq_hi_nz | (bit_e & mul_hi_nz);
  end

  // Next-state and next-register computation for the controller and datapath.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf_s_d     = ovf_s_q;
    base_d      = base_q;
    exp_d       = exp_q;
    resultado_d = resultado_q;
    overflow_d  = overflow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          base_d  = base;
          exp_d   = exponente;
          acc_d   = M'(1);
          ovf_s_d = 1'b0;
          cnt_d   = CNT_W'(M - 1);
        end
      end
      RUN: begin
        acc_d   = step_acc;
        ovf_s_d = step_ovf;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d     = DONE;
          overflow_d  = step_ovf;
          resultado_d = (SATURATE && step_ovf) ? {M{1'b1}} : step_acc;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, iteration and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_s_q     <= 1'b0;
      base_q      <= '0;
      exp_q       <= '0;
      resultado_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_s_q     <= ovf_s_d;
      base_q      <= base_d;
      exp_q       <= exp_d;
      resultado_q <= resultado_d;
      overflow_q  <= overflow_d;
    end
  end

  assign resultado = resultado_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_exponencial_secuencial.sv
// Scoreboard bench for exponencial_secuencial: M=4 wrap, M=4 saturating, M=8 wrap.
module tb_exponencial_secuencial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start4;
  logic [3:0] base4, exp4;
  logic [3:0] res4, res4s;
  logic       ovf4, busy4, done4, ovf4s, busy4s, done4s;

  logic       start8;
  logic [7:0] base8, exp8, res8;
  logic       ovf8, busy8, done8;

  exponencial_secuencial #(.M(4), .SATURATE(1'b0)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .base(base4), .exponente(exp4),
    .resultado(res4), .overflow(ovf4), .busy(busy4), .done(done4));

  exponencial_secuencial #(.M(4), .SATURATE(1'b1)) dut4s (
    .clk(clk), .rst(rst), .start(start4), .base(base4), .exponente(exp4),
    .resultado(res4s), .overflow(ovf4s), .busy(busy4s), .done(done4s));

  exponencial_secuencial #(.M(8), .SATURATE(1'b0)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .base(base8), .exponente(exp8),
    .resultado(res8), .overflow(ovf8), .busy(busy8), .done(done8));

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q4s[$];
  exp_t q8[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cmp_txn(input string name, input exp_t e, input logic [7:0] r, input logic o);
    $display("txn %s res=%0d ovf=%0d cyc=%0d (exp res=%0d ovf=%0d cyc=%0d)",
             name, r, o, cyc, e.res, e.ovf, e.cyc);
    chk({name, "_resultado"}, {24'b0, r}, {24'b0, e.res});
    chk({name, "_overflow"}, {31'b0, o}, {31'b0, e.ovf});
    chk({name, "_latency"}, cyc, e.cyc);
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s_unexpected_done: got done=1 expected no pending op (t=%0t)", name, $time);
  endtask

  // Monitor: pops one expectation per done pulse on each DUT.
  always @(negedge clk) begin
    exp_t e;
    if (done4 === 1'b1) begin
      if (q4.size() == 0) unexpected("dut4");
      else begin e = q4.pop_front(); cmp_txn("dut4", e, {4'b0, res4}, ovf4); end
    end
    if (done4s === 1'b1) begin
      if (q4s.size() == 0) unexpected("dut4s");
      else begin e = q4s.pop_front(); cmp_txn("dut4s", e, {4'b0, res4s}, ovf4s); end
    end
    if (done8 === 1'b1) begin
      if (q8.size() == 0) unexpected("dut8");
      else begin e = q8.pop_front(); cmp_txn("dut8", e, res8, ovf8); end
    end
  end

  // Issue one 4-bit operation to both M=4 units and wait until they are idle again.
  task automatic op4(input logic [3:0] b, input logic [3:0] e,
                     input logic [3:0] r, input logic o, input logic [3:0] rs);
    @(negedge clk);
    base4 = b; exp4 = e; start4 = 1'b1;
    q4.push_back(exp_t'{res: {4'b0, r}, ovf: o, cyc: cyc + 5});
    q4s.push_back(exp_t'{res: {4'b0, rs}, ovf: o, cyc: cyc + 5});
    @(negedge clk);
    start4 = 1'b0;
    chk("busy4_in_run", {31'b0, busy4}, 32'd1);
    repeat (5) @(negedge clk);
  endtask

  // Repeated-multiplication reference for M=8 (independent of square-and-multiply).
  task automatic ref8(input int b, input int e, output logic [7:0] r, output logic o);
    int rm, tr;
    rm = 1; tr = 1;
    for (int i = 0; i < e; i++) begin
      rm = (rm * b) & 255;
      tr = tr * b;
      if (tr > 255) tr = 256;
    end
    r = rm[7:0];
    o = (tr > 255);
  endtask

  task automatic op8(input logic [7:0] b, input logic [7:0] e, input logic [7:0] r, input logic o);
    @(negedge clk);
    base8 = b; exp8 = e; start8 = 1'b1;
    q8.push_back(exp_t'{res: r, ovf: o, cyc: cyc + 9});
    @(negedge clk);
    start8 = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  initial begin
    logic [7:0] r8;
    logic       o8;
    int         b, e;
    rst = 1'b1; start4 = 1'b0; base4 = '0; exp4 = '0;
    start8 = 1'b0; base8 = '0; exp8 = '0;
    repeat (2) @(negedge clk);
    chk("reset_resultado", {28'b0, res4}, 32'd0);
    chk("reset_overflow", {31'b0, ovf4}, 32'd0);
    chk("reset_busy", {31'b0, busy4}, 32'd0);
    chk("reset_done", {31'b0, done4}, 32'd0);
    rst = 1'b0;

    // Directed M=4 vectors: base, exp, wrap result, overflow, saturated result.
    op4(4'd3, 4'd2, 4'd9, 1'b0, 4'd9);
    op4(4'd3, 4'd3, 4'd11, 1'b1, 4'd15);
    op4(4'd0, 4'd0, 4'd1, 1'b0, 4'd1);
    op4(4'd15, 4'd0, 4'd1, 1'b0, 4'd1);
    op4(4'd0, 4'd5, 4'd0, 1'b0, 4'd0);
    op4(4'd1, 4'd15, 4'd1, 1'b0, 4'd1);
    op4(4'd15, 4'd2, 4'd1, 1'b1, 4'd15);
    op4(4'd2, 4'd4, 4'd0, 1'b1, 4'd15);
    op4(4'd2, 4'd3, 4'd8, 1'b0, 4'd8);
    repeat (3) @(negedge clk);
    chk("held_resultado", {28'b0, res4}, 32'd8);

    // start pulsed during RUN with other operands must be ignored.
    @(negedge clk);
    base4 = 4'd3; exp4 = 4'd2; start4 = 1'b1;
    q4.push_back(exp_t'{res: 8'd9, ovf: 1'b0, cyc: cyc + 5});
    q4s.push_back(exp_t'{res: 8'd9, ovf: 1'b0, cyc: cyc + 5});
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); base4 = 4'd2; exp4 = 4'd4; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    repeat (5) @(negedge clk);

    // start held high: second op accepted at the first IDLE edge after DONE.
    @(negedge clk);
    base4 = 4'd2; exp4 = 4'd3; start4 = 1'b1;
    q4.push_back(exp_t'{res: 8'd8, ovf: 1'b0, cyc: cyc + 5});
    q4.push_back(exp_t'{res: 8'd8, ovf: 1'b0, cyc: cyc + 11});
    q4s.push_back(exp_t'{res: 8'd8, ovf: 1'b0, cyc: cyc + 5});
    q4s.push_back(exp_t'{res: 8'd8, ovf: 1'b0, cyc: cyc + 11});
    repeat (7) @(negedge clk);
    start4 = 1'b0;
    repeat (6) @(negedge clk);

    // Reset in the second RUN cycle aborts without a done pulse.
    @(negedge clk);
    base4 = 4'd3; exp4 = 4'd3; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy4}, 32'd0);
    chk("abort_done", {31'b0, done4}, 32'd0);
    chk("abort_resultado", {28'b0, res4}, 32'd0);
    chk("abort_overflow", {31'b0, ovf4}, 32'd0);
    chk("abort_resultado_sat", {28'b0, res4s}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    op4(4'd3, 4'd3, 4'd11, 1'b1, 4'd15);

    // M=8 directed boundaries.
    op8(8'd2, 8'd7, 8'd128, 1'b0);
    op8(8'd2, 8'd8, 8'd0, 1'b1);
    op8(8'd3, 8'd5, 8'd243, 1'b0);
    op8(8'd3, 8'd6, 8'd217, 1'b1);
    op8(8'd255, 8'd1, 8'd255, 1'b0);
    op8(8'd16, 8'd2, 8'd0, 1'b1);
    op8(8'd0, 8'd0, 8'd1, 1'b0);

    // M=8 random pairs against the reference model.
    for (int i = 0; i < 300; i++) begin
      b = int'($urandom_range(0, 255));
      e = (i % 2 == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255));
      ref8(b, e, r8, o8);
      op8(b[7:0], e[7:0], r8, o8);
    end

    repeat (3) @(negedge clk);
    chk("q4_drained", q4.size(), 32'd0);
    chk("q4s_drained", q4s.size(), 32'd0);
    chk("q8_drained", q8.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
